// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the core load/store unit
// (requester C) and a debug/loader port (requester D). Accesses are
// serialised by a three-state FSM (IDLE -> ACCESS -> [WAIT] -> IDLE).
// Read data is returned to whichever requester issued the read.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin on simultaneous requests (non-last-winner wins)
//   undefined : fixed priority, C always wins a tie
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata   core request and its fields
//   c_gnt                       core request accepted (combinational pulse)
//   c_rvalid/c_rdata            core read data return (rdata 0 when invalid)
//   c_stall                     core waiting for a grant
//   d_req/d_we/d_addr/d_wdata   debug request and its fields
//   d_gnt, d_rvalid/d_rdata     debug grant and read data return
//   mem_wr/mem_rd               memory strobes (registered, ACCESS only)
//   mem_addr/mem_wr_data        memory address / write data (captured regs)
//   mem_rd_data                 memory read data, valid MEM_LAT after mem_rd
//   busy                        FSM not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic       WIN_C    = 1'b0;
    localparam logic       WIN_D    = 1'b1;
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t              state;
    logic [2:0]          lat_cnt;
    logic                last_winner;
    logic                winner;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;

    logic                grant;
    logic                pick_d;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                rd_done;

    // Arbitration: grants only in IDLE and never in a reset cycle.
    always_comb begin
        grant  = 1'b0;
        pick_d = 1'b0;
        if ((state == IDLE) && !reset && (c_req || d_req)) begin
            grant = 1'b1;
            if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
                // Tie goes to whoever did not win last time.
                pick_d = (last_winner == WIN_C);
`else
                pick_d = 1'b0;
`endif
            end else begin
                pick_d = d_req;
            end
        end else begin
            grant  = 1'b0;
            pick_d = 1'b0;
        end
    end

    // Field mux for the winning requester.
    always_comb begin
        if (pick_d) begin
            sel_we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end else begin
            sel_we    = c_we;
            sel_addr  = c_addr;
            sel_wdata = c_wdata;
        end
    end

    assign c_gnt   = grant & ~pick_d;
    assign d_gnt   = grant & pick_d;
    assign c_stall = c_req & ~c_gnt;
    assign busy    = (state != IDLE);

    // Read return lands in the last WAIT cycle; a reset in that cycle kills it.
    assign rd_done  = (state == WAIT) && (lat_cnt == 3'd1) && !reset;
    assign c_rvalid = rd_done && (winner == WIN_C);
    assign d_rvalid = rd_done && (winner == WIN_D);
    assign c_rdata  = c_rvalid ? mem_rd_data : {DATA_W{1'b0}};
    assign d_rdata  = d_rvalid ? mem_rd_data : {DATA_W{1'b0}};

    // Memory address/data are driven straight from the capture registers so
    // they hold their last value outside ACCESS.
    assign mem_addr    = cap_addr;
    assign mem_wr_data = cap_wdata;

    // FSM, capture registers and registered memory strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lat_cnt     <= 3'd0;
            last_winner <= WIN_D;
            winner      <= WIN_C;
            cap_we      <= 1'b0;
            cap_addr    <= {ADDR_W{1'b0}};
            cap_wdata   <= {DATA_W{1'b0}};
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        winner      <= pick_d;
                        last_winner <= pick_d;
                        cap_we      <= sel_we;
                        cap_addr    <= sel_addr;
                        cap_wdata   <= sel_wdata;
                        // Strobes are registered so they appear in ACCESS.
                        mem_wr      <= sel_we;
                        mem_rd      <= ~sel_we;
                        state       <= ACCESS;
                    end else begin
                        mem_wr <= 1'b0;
                        mem_rd <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    if (cap_we) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    if (lat_cnt == 3'd1) begin
                        lat_cnt <= 3'd0;
                        state   <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    mem_wr  <= 1'b0;
                    mem_rd  <= 1'b0;
                    lat_cnt <= 3'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with MEM_LAT=3. A behavioural memory
// with a read-latency pipeline sits on the memory port. Expected grants,
// read data and memory writes are queued when stimulus is driven and
// compared by a monitor when the DUT produces them; timing points are
// checked inline. Inputs change #1 after posedge, outputs sampled on negedge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          mem_wr, mem_rd, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_rd_cnt = 0;

    logic [DW-1:0]    c_exp[$];
    logic [DW-1:0]    d_exp[$];
    logic             gnt_exp[$];
    logic [AW+DW-1:0] wr_exp[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hA500_0000 | {23'd0, a};
    endfunction

    // Behavioural memory: unwritten words read as init_val(addr).
    bit   [DW-1:0] mem [0:511];
    bit   [511:0]  wr_ok;
    logic [DW-1:0] pipe [0:LAT-1];
    assign mem_rd_data = pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr]   <= mem_wr_data;
            wr_ok[mem_addr] <= 1'b1;
        end
        pipe[0] <= mem_rd ? (wr_ok[mem_addr] ? mem[mem_addr] : init_val(mem_addr))
                          : 32'hBADD_BADD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        to_mid();
        while (busy && k < 30) begin
            to_next();
            to_mid();
            k++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        to_next();
    endtask

    // Scoreboard monitor: pops expectations as the DUT produces results.
    always @(negedge clk) begin
        if (c_gnt || d_gnt) begin
            check("gnt_onehot", 64'(c_gnt & d_gnt), 64'd0);
            if (gnt_exp.size() == 0) check("gnt_spurious", 64'({c_gnt, d_gnt}), 64'd0);
            else check("gnt_who", 64'(d_gnt), 64'(gnt_exp.pop_front()));
        end
        if (c_rvalid) begin
            if (c_exp.size() == 0) check("c_rvalid_spurious", 64'(c_rvalid), 64'd0);
            else check("c_rdata", 64'(c_rdata), 64'(c_exp.pop_front()));
        end
        if (d_rvalid) begin
            if (d_exp.size() == 0) check("d_rvalid_spurious", 64'(d_rvalid), 64'd0);
            else check("d_rdata", 64'(d_rdata), 64'(d_exp.pop_front()));
        end
        if (mem_wr) begin
            if (wr_exp.size() == 0) check("mem_wr_spurious", 64'(mem_wr), 64'd0);
            else check("mem_wr_fields", 64'({mem_addr, mem_wr_data}), 64'(wr_exp.pop_front()));
        end
        if (mem_rd) mem_rd_cnt++;
    end

    initial begin
        int c_left, d_left, prev, ngr, rd0;
        logic exp_order [0:2];

        // ---------------- reset, with a same-cycle request ----------------
        reset = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005; c_wdata = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 9'h000; d_wdata = 32'd0;
        to_mid();
        check("rst_c_gnt", 64'(c_gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({mem_wr, mem_rd, c_rvalid, d_rvalid, d_gnt}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wr_data), 64'd0);
        check("rst_rdata", 64'({c_rdata, d_rdata}), 64'd0);
        to_next();
        reset = 1'b0; c_req = 1'b0;

        // ---------------- core write 0x010 = DEADBEEF ----------------
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h010; c_wdata = 32'hDEAD_BEEF;
        gnt_exp.push_back(1'b0);
        wr_exp.push_back({9'h010, 32'hDEAD_BEEF});
        to_mid();
        check("wr_c_gnt", 64'(c_gnt), 64'd1);
        check("wr_c_stall", 64'(c_stall), 64'd0);
        to_next();
        c_req = 1'b0; c_we = 1'b0;
        to_mid();
        check("wr_mem_wr", 64'({mem_wr, mem_rd}), 64'b10);
        check("wr_mem_addr", 64'(mem_addr), 64'h010);
        check("wr_busy", 64'(busy), 64'd1);
        to_next();
        to_mid();
        check("wr_busy_done", 64'(busy), 64'd0);
        check("wr_addr_hold", 64'(mem_addr), 64'h010);
        check("wr_no_strobe", 64'({mem_wr, mem_rd, c_rvalid}), 64'd0);
        to_next();

        // ---------------- core read 0x010 ----------------
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010;
        gnt_exp.push_back(1'b0);
        c_exp.push_back(32'hDEAD_BEEF);
        to_mid();
        check("rd_c_gnt", 64'(c_gnt), 64'd1);
        to_next();
        c_req = 1'b0;
        to_mid();
        check("rd_mem_rd", 64'({mem_wr, mem_rd}), 64'b01);
        check("rd_mem_addr", 64'(mem_addr), 64'h010);
        to_next();
        for (int k = 2; k <= LAT; k++) begin
            to_mid();
            check("rd_early", 64'(c_rvalid), 64'd0);
            to_next();
        end
        to_mid();
        check("rd_c_rvalid", 64'(c_rvalid), 64'd1);
        check("rd_c_rdata", 64'(c_rdata), 64'hDEAD_BEEF);
        check("rd_d_rvalid", 64'(d_rvalid), 64'd0);
        to_next();
        to_mid();
        check("rd_idle", 64'({busy, c_rvalid}), 64'd0);
        check("rd_rdata_zero", 64'(c_rdata), 64'd0);
        to_next();

        // ---------------- reset so the tie test starts with last_winner=D ----------------
        reset = 1'b1;
        to_mid();
        to_next();
        reset = 1'b0;

        // ---------------- simultaneous reads: C wants 2, D wants 1 ----------------
`ifdef DMEM_ARB_RR_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`endif
        for (int i = 0; i < 3; i++) gnt_exp.push_back(exp_order[i]);
        c_exp.push_back(init_val(9'h020));
        c_exp.push_back(init_val(9'h020));
        d_exp.push_back(init_val(9'h030));
        c_left = 2; d_left = 1; prev = 0; ngr = 0;
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        c_addr = 9'h020; d_addr = 9'h030;
        for (int cyc = 0; cyc < 40 && (c_left > 0 || d_left > 0); cyc++) begin
            to_mid();
            if (c_gnt || d_gnt) begin
                if (ngr == 0) check("tie_first_cycle", 64'(cyc), 64'd0);
                else check("tie_gap", 64'(cyc - prev), 64'(2 + LAT));
                prev = cyc;
                ngr++;
            end
            if (c_gnt) c_left--;
            if (d_gnt) d_left--;
            to_next();
            if (c_left == 0) c_req = 1'b0;
            if (d_left == 0) d_req = 1'b0;
        end
        c_req = 1'b0; d_req = 1'b0;
        check("tie_all_granted", 64'(c_left + d_left), 64'd0);
        wait_idle();

        // ---------------- D read in WAIT, core request arrives at T+2 ----------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
        gnt_exp.push_back(1'b1);
        d_exp.push_back(init_val(9'h040));
        to_mid();
        check("dw_d_gnt", 64'(d_gnt), 64'd1);
        to_next();
        d_req = 1'b0;
        to_mid();
        to_next();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h050;
        gnt_exp.push_back(1'b0);
        c_exp.push_back(init_val(9'h050));
        for (int k = 2; k <= 1 + LAT; k++) begin
            to_mid();
            check("dw_c_stall", 64'(c_stall), 64'd1);
            check("dw_c_gnt_early", 64'(c_gnt), 64'd0);
            check("dw_d_rvalid", 64'(d_rvalid), (k == 1 + LAT) ? 64'd1 : 64'd0);
            to_next();
        end
        to_mid();
        check("dw_c_gnt", 64'(c_gnt), 64'd1);
        check("dw_c_stall_end", 64'(c_stall), 64'd0);
        to_next();
        c_req = 1'b0;
        wait_idle();

        // ---------------- reset during ACCESS of a read ----------------
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h070;
        gnt_exp.push_back(1'b0);
        to_mid();
        check("ra_c_gnt", 64'(c_gnt), 64'd1);
        to_next();
        c_req = 1'b0; reset = 1'b1;
        to_mid();
        check("ra_mem_rd", 64'(mem_rd), 64'd1);
        to_next();
        reset = 1'b0;
        rd0 = mem_rd_cnt;
        to_mid();
        check("ra_busy", 64'(busy), 64'd0);
        check("ra_strobes", 64'({mem_wr, mem_rd, c_rvalid, d_rvalid}), 64'd0);
        check("ra_mem_addr", 64'(mem_addr), 64'd0);
        check("ra_mem_wdata", 64'(mem_wr_data), 64'd0);
        to_next();
        repeat (LAT + 3) begin
            to_mid();
            to_next();
        end
        check("ra_no_more_rd", 64'(mem_rd_cnt), 64'(rd0));

        // ---------------- D request withdrawn while C is busy ----------------
        rd0 = mem_rd_cnt;
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h080;
        gnt_exp.push_back(1'b0);
        c_exp.push_back(init_val(9'h080));
        to_mid();
        check("wd_c_gnt", 64'(c_gnt), 64'd1);
        to_next();
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h090; d_wdata = 32'h0000_1234;
        for (int k = 1; k <= 3; k++) begin
            to_mid();
            check("wd_no_d_gnt", 64'(d_gnt), 64'd0);
            check("wd_busy", 64'(busy), 64'd1);
            to_next();
        end
        d_req = 1'b0;
        wait_idle();
        repeat (3) begin
            to_mid();
            to_next();
        end
        check("wd_rd_count", 64'(mem_rd_cnt), 64'(rd0 + 1));

        // ---------------- leftover expectations ----------------
        check("c_exp_left", 64'(c_exp.size()), 64'd0);
        check("d_exp_left", 64'(d_exp.size()), 64'd0);
        check("gnt_exp_left", 64'(gnt_exp.size()), 64'd0);
        check("wr_exp_left", 64'(wr_exp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
